key_debounce: RTL and testbench

Debounces the four active-low push-buttons on the 12 MHz clock and turns each clean press into a one-cycle pulse. It also holds a one-hot mode register, `key_out`, that records the last key pressed. It sits between the raw `key_input` pins and the mode consumers, `driver_selector` and `seg_display`. The LED pattern therefore changes exactly once per physical press, with no bounce-induced mode skipping.

---
 rtl/key_pkg.sv | 16 +
 rtl/key_db_chan.sv | 126 ++++++++++++
 rtl/key_debounce.sv | 51 +++++
 tb/tb_key_debounce.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// Shared constants and state encoding for the key debouncer.
package key_pkg;

  localparam int unsigned N_KEYS = 4;
  localparam int unsigned DB_CYCLES_DEF = 240000;  // 20 ms at 12 MHz

  localparam logic [3:0] MODE_RESET = 4'b0001;

  typedef enum logic [1:0] {
    UP,
    WAIT_DN,
    DOWN,
    WAIT_UP
  } db_state_t;

endpackage

// File: rtl/key_db_chan.sv
// One debounce channel: 2-flop synchronizer, stability counter and press/release FSM.
// KEY_DEBOUNCE_RELEASE_EVT_EN adds the release_evt pulse output.
module key_db_chan
  import key_pkg::*;
#(
  parameter int unsigned DB_CYCLES = DB_CYCLES_DEF,
  parameter int unsigned CNT_W     = $clog2(DB_CYCLES)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic level,
`ifdef KEY_DEBOUNCE_RELEASE_EVT_EN
  output logic release_evt,
`endif
  output logic press
);

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DB_CYCLES - 1);

  logic [1:0] sync_q;
  logic       sync;

  db_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic             press_q, press_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[0], ~key_n};
    end
  end

  assign sync    = sync_q[1];
  assign cnt_inc = cnt_q + CNT_W'(1);

`ifdef KEY_DEBOUNCE_RELEASE_EVT_EN
  logic rel_q, rel_d;
`endif

  // The UP/DOWN cycle that sees the new level counts toward stability, so the
  // wait state exits when the incremented count hits DB_CYCLES-1.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    press_d = 1'b0;
`ifdef KEY_DEBOUNCE_RELEASE_EVT_EN
    rel_d   = 1'b0;
`endif
    unique case (state_q)
      UP: begin
        if (sync) begin
          state_d = WAIT_DN;
          cnt_d   = '0;
        end
      end
      WAIT_DN: begin
        if (!sync) begin
          state_d = UP;
          cnt_d   = '0;
        end else if (cnt_inc == CntLast) begin
          state_d = DOWN;
          cnt_d   = '0;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      DOWN: begin
        if (!sync) begin
          state_d = WAIT_UP;
          cnt_d   = '0;
        end
      end
      WAIT_UP: begin
        if (sync) begin
          state_d = DOWN;
          cnt_d   = '0;
        end else if (cnt_inc == CntLast) begin
          state_d = UP;
          cnt_d   = '0;
`ifdef KEY_DEBOUNCE_RELEASE_EVT_EN
          rel_d   = 1'b1;
`endif
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = UP;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= UP;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

`ifdef KEY_DEBOUNCE_RELEASE_EVT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rel_q <= 1'b0;
    end else begin
      rel_q <= rel_d;
    end
  end

  assign release_evt = rel_q;
`endif

  assign level = (state_q == DOWN) || (state_q == WAIT_UP);
  assign press = press_q;

endmodule

// File: rtl/key_debounce.sv
// Debounces active-low keys into press pulses and a one-hot "last key pressed" mode register.
// KEY_DEBOUNCE_RELEASE_EVT_EN adds the key_release pulse output.
module key_debounce #(
  parameter int unsigned N_KEYS    = key_pkg::N_KEYS,
  parameter int unsigned DB_CYCLES = key_pkg::DB_CYCLES_DEF,
  parameter int unsigned CNT_W     = $clog2(DB_CYCLES)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_KEYS-1:0] key_in,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
`ifdef KEY_DEBOUNCE_RELEASE_EVT_EN
  output logic [N_KEYS-1:0] key_release,
`endif
  output logic [N_KEYS-1:0] key_out
);

  logic [N_KEYS-1:0] press_sel;
  logic [N_KEYS-1:0] key_out_q;

  for (genvar i = 0; i < N_KEYS; i++) begin : g_chan
    key_db_chan #(
      .DB_CYCLES(DB_CYCLES),
      .CNT_W    (CNT_W)
    ) u_chan (
      .clk        (clk),
      .rst_n      (rst_n),
      .key_n      (key_in[i]),
      .level      (key_level[i]),
`ifdef KEY_DEBOUNCE_RELEASE_EVT_EN
      .release_evt(key_release[i]),
`endif
      .press      (key_press[i])
    );
  end

  // Isolate the lowest set bit: simultaneous presses resolve to the lowest index.
  assign press_sel = key_press & (~key_press + N_KEYS'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_out_q <= N_KEYS'(key_pkg::MODE_RESET);
    end else if (|key_press) begin
      key_out_q <= press_sel;
    end
  end

  assign key_out = key_out_q;

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce with DB_CYCLES=8; edge counts are relative to the
// clock edge just before an input change.
module tb_key_debounce;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] key_in = 4'hF;
  logic [3:0] key_level, key_press, key_out;
`ifdef KEY_DEBOUNCE_RELEASE_EVT_EN
  logic [3:0] key_release;
`endif

  int n_vec = 0;
  int n_err = 0;

  key_debounce #(
    .N_KEYS   (4),
    .DB_CYCLES(8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_in     (key_in),
    .key_level  (key_level),
    .key_press  (key_press),
`ifdef KEY_DEBOUNCE_RELEASE_EVT_EN
    .key_release(key_release),
`endif
    .key_out    (key_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    key_in = 4'hF;
    for (int i = 0; i < 12; i++) tick();
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    key_in = 4'hF;
    for (int i = 0; i < 3; i++) tick();
    n_vec++;
    if ({key_press, key_level, key_out} !== {4'b0000, 4'b0000, 4'b0001}) begin
      n_err++;
      $display("FAIL reset: press/level/out got %b/%b/%b want 0000/0000/0001",
               key_press, key_level, key_out);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    n_vec++;
    if ({key_press, key_level, key_out} !== {4'b0000, 4'b0000, 4'b0001}) begin
      n_err++;
      $display("FAIL reset_idle: press/level/out got %b/%b/%b want 0000/0000/0001",
               key_press, key_level, key_out);
    end
  endtask

  task automatic test_clean_press();
    logic [3:0] ep, el, eo;
    key_in = 4'b1011;
    for (int i = 1; i <= 30; i++) begin
      tick();
      ep = (i == 10) ? 4'b0100 : 4'b0000;
      el = (i >= 10) ? 4'b0100 : 4'b0000;
      eo = (i >= 11) ? 4'b0100 : 4'b0001;
      n_vec++;
      if ({key_press, key_level, key_out} !== {ep, el, eo}) begin
        n_err++;
        $display("FAIL clean_press step %0d: press/level/out got %b/%b/%b want %b/%b/%b",
                 i, key_press, key_level, key_out, ep, el, eo);
      end
    end
    key_in = 4'hF;
    for (int i = 1; i <= 12; i++) begin
      tick();
      el = (i < 10) ? 4'b0100 : 4'b0000;
      n_vec++;
      if ({key_press, key_level, key_out} !== {4'b0000, el, 4'b0100}) begin
        n_err++;
        $display("FAIL clean_release step %0d: press/level/out got %b/%b/%b want 0000/%b/0100",
                 i, key_press, key_level, key_out, el);
      end
    end
  endtask

  task automatic test_bounce();
    logic [3:0] ep, el, eo;
    key_in = 4'b1101;
    for (int i = 1; i <= 7; i++) begin
      if (i == 6) key_in = 4'hF;
      tick();
      n_vec++;
      if ({key_press, key_level, key_out} !== {4'b0000, 4'b0000, 4'b0100}) begin
        n_err++;
        $display("FAIL bounce_early step %0d: press/level/out got %b/%b/%b want 0000/0000/0100",
                 i, key_press, key_level, key_out);
      end
    end
    key_in = 4'b1101;
    for (int i = 1; i <= 14; i++) begin
      tick();
      ep = (i == 10) ? 4'b0010 : 4'b0000;
      el = (i >= 10) ? 4'b0010 : 4'b0000;
      eo = (i >= 11) ? 4'b0010 : 4'b0100;
      n_vec++;
      if ({key_press, key_level, key_out} !== {ep, el, eo}) begin
        n_err++;
        $display("FAIL bounce step %0d: press/level/out got %b/%b/%b want %b/%b/%b",
                 i, key_press, key_level, key_out, ep, el, eo);
      end
    end
    settle();
  endtask

  task automatic test_glitch();
    logic [3:0] ep, el, eo;
    // 7 cycles low: one short of acceptance.
    key_in = 4'b0111;
    for (int i = 1; i <= 15; i++) begin
      tick();
      if (i == 7) key_in = 4'hF;
      n_vec++;
      if ({key_press, key_level, key_out} !== {4'b0000, 4'b0000, 4'b0010}) begin
        n_err++;
        $display("FAIL glitch7 step %0d: press/level/out got %b/%b/%b want 0000/0000/0010",
                 i, key_press, key_level, key_out);
      end
    end
    // 8 cycles low: exactly enough.
    key_in = 4'b1110;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 8) key_in = 4'hF;
      ep = (i == 10) ? 4'b0001 : 4'b0000;
      el = (i >= 10 && i < 18) ? 4'b0001 : 4'b0000;
      eo = (i >= 11) ? 4'b0001 : 4'b0010;
      n_vec++;
      if ({key_press, key_level, key_out} !== {ep, el, eo}) begin
        n_err++;
        $display("FAIL glitch8 step %0d: press/level/out got %b/%b/%b want %b/%b/%b",
                 i, key_press, key_level, key_out, ep, el, eo);
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [3:0] ep, el, eo;
    key_in = 4'b0101;
    for (int i = 1; i <= 12; i++) begin
      tick();
      ep = (i == 10) ? 4'b1010 : 4'b0000;
      el = (i >= 10) ? 4'b1010 : 4'b0000;
      eo = (i >= 11) ? 4'b0010 : 4'b0001;
      n_vec++;
      if ({key_press, key_level, key_out} !== {ep, el, eo}) begin
        n_err++;
        $display("FAIL simultaneous step %0d: press/level/out got %b/%b/%b want %b/%b/%b",
                 i, key_press, key_level, key_out, ep, el, eo);
      end
    end
    settle();
  endtask

  task automatic test_reset_mid_count();
    logic [3:0] ep, el;
    key_in = 4'b1110;
    for (int i = 1; i <= 8; i++) tick();
    n_vec++;
    if ({key_press, key_level, key_out} !== {4'b0000, 4'b0000, 4'b0010}) begin
      n_err++;
      $display("FAIL midreset_pre: press/level/out got %b/%b/%b want 0000/0000/0010",
               key_press, key_level, key_out);
    end
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({key_press, key_level, key_out} !== {4'b0000, 4'b0000, 4'b0001}) begin
      n_err++;
      $display("FAIL midreset_async: press/level/out got %b/%b/%b want 0000/0000/0001",
               key_press, key_level, key_out);
    end
    for (int i = 0; i < 3; i++) tick();
    rst_n = 1'b1;
    for (int i = 1; i <= 14; i++) begin
      tick();
      ep = (i == 10) ? 4'b0001 : 4'b0000;
      el = (i >= 10) ? 4'b0001 : 4'b0000;
      n_vec++;
      if ({key_press, key_level, key_out} !== {ep, el, 4'b0001}) begin
        n_err++;
        $display("FAIL midreset step %0d: press/level/out got %b/%b/%b want %b/%b/0001",
                 i, key_press, key_level, key_out, ep, el);
      end
    end
    settle();
  endtask

`ifdef KEY_DEBOUNCE_RELEASE_EVT_EN
  task automatic test_release_evt();
    logic [3:0] er, el;
    key_in = 4'b1011;
    for (int i = 0; i < 12; i++) tick();
    key_in = 4'hF;
    for (int i = 1; i <= 12; i++) begin
      tick();
      er = (i == 10) ? 4'b0100 : 4'b0000;
      el = (i < 10) ? 4'b0100 : 4'b0000;
      n_vec++;
      if ({key_release, key_level, key_press} !== {er, el, 4'b0000}) begin
        n_err++;
        $display("FAIL release_evt step %0d: release/level/press got %b/%b/%b want %b/%b/0000",
                 i, key_release, key_level, key_press, er, el);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_glitch();
    test_simultaneous();
    test_reset_mid_count();
`ifdef KEY_DEBOUNCE_RELEASE_EVT_EN
    test_release_evt();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
